// File: rtl/gnss_clock_monitor_if.sv
// Status/clock bundle between the GNSS clock monitor and its surroundings.
// DUTY_CHECK_EN adds the latched high-time outputs.
interface gnss_clock_monitor_if;
  logic        in_clock_GLONASS;
  logic        in_clock_GPS;
  logic        in_clear_fault;
  logic        out_lock_GLONASS;
  logic        out_lock_GPS;
  logic        out_fault_GLONASS;
  logic        out_fault_GPS;
  logic [27:0] out_period_GLONASS;
  logic [27:0] out_period_GPS;
`ifdef DUTY_CHECK_EN
  logic [27:0] out_high_GLONASS;
  logic [27:0] out_high_GPS;

  modport master (
    output in_clock_GLONASS, in_clock_GPS, in_clear_fault,
    input  out_lock_GLONASS, out_lock_GPS,
    input  out_fault_GLONASS, out_fault_GPS,
    input  out_period_GLONASS, out_period_GPS,
    input  out_high_GLONASS, out_high_GPS
  );
  modport slave (
    input  in_clock_GLONASS, in_clock_GPS, in_clear_fault,
    output out_lock_GLONASS, out_lock_GPS,
    output out_fault_GLONASS, out_fault_GPS,
    output out_period_GLONASS, out_period_GPS,
    output out_high_GLONASS, out_high_GPS
  );
`else
  modport master (
    output in_clock_GLONASS, in_clock_GPS, in_clear_fault,
    input  out_lock_GLONASS, out_lock_GPS,
    input  out_fault_GLONASS, out_fault_GPS,
    input  out_period_GLONASS, out_period_GPS
  );
  modport slave (
    input  in_clock_GLONASS, in_clock_GPS, in_clear_fault,
    output out_lock_GLONASS, out_lock_GPS,
    output out_fault_GLONASS, out_fault_GPS,
    output out_period_GLONASS, out_period_GPS
  );
`endif
endinterface

// File: rtl/gnss_clock_monitor.sv
// Period/lock monitor for the divided GLONASS and GPS sample clocks.
// Optional high-time check enabled by DUTY_CHECK_EN.
module gnss_clock_monitor #(
  parameter logic [27:0] DIVISOR_GLONASS = 28'd25,
  parameter logic [27:0] DIVISOR_GPS     = 28'd50,
  parameter logic [27:0] TOLERANCE       = 28'd1,
  parameter int          LOCK_COUNT      = 4,
  parameter logic [27:0] TIMEOUT         = 28'd255
) (
  input logic in_clock,
  input logic in_reset,
  gnss_clock_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED,
    LOST
  } state_t;

  localparam logic [27:0] CNT_MAX = 28'hFFFFFFF;
  localparam logic [3:0]  LOCK_N  = 4'(LOCK_COUNT);

  logic [1:0]  clk_a;
  logic [1:0]  lock_w;
  logic [1:0]  fault_w;
  logic [27:0] period_w [2];
`ifdef DUTY_CHECK_EN
  logic [27:0] high_w [2];
`endif

  assign clk_a = {bus.in_clock_GPS, bus.in_clock_GLONASS};

  for (genvar g = 0; g < 2; g++) begin : g_ch
    localparam logic [27:0] DIV =
      (g == 0) ? DIVISOR_GLONASS : DIVISOR_GPS;
    localparam logic [28:0] HI =
      {1'b0, DIV} + {1'b0, TOLERANCE};
    localparam logic [28:0] LO =
      (DIV >= TOLERANCE) ? {1'b0, DIV - TOLERANCE} : 29'd0;

    logic        s1_q, s2_q, sd_q;
    logic        seen_q;
    logic [27:0] cnt_q, cnt_d;
    logic [27:0] period_q;
    logic [3:0]  good_q;
    logic        lock_q, fault_q;
    state_t      state_q;
    logic        rise, good, high_ok;

    assign rise = s2_q & ~sd_q;

`ifdef DUTY_CHECK_EN
    localparam logic [27:0] HDIV = DIV >> 1;
    localparam logic [28:0] HHI =
      {1'b0, HDIV} + {1'b0, TOLERANCE};
    localparam logic [28:0] HLO =
      (HDIV >= TOLERANCE) ? {1'b0, HDIV - TOLERANCE} : 29'd0;

    logic        fall;
    logic [27:0] hcnt_q, hcnt_d;
    logic [27:0] high_q;

    assign fall = ~s2_q & sd_q;
    assign high_ok = ({1'b0, high_q} >= HLO)
                   && ({1'b0, high_q} <= HHI);

    // The rise cycle itself is the first high cycle.
    always_comb begin
      hcnt_d = hcnt_q;
      if (rise) hcnt_d = 28'd1;
      else if (s2_q && hcnt_q != CNT_MAX)
        hcnt_d = hcnt_q + 28'd1;
    end

    always_ff @(posedge in_clock or posedge in_reset) begin
      if (in_reset) begin
        hcnt_q <= '0;
        high_q <= '0;
      end else begin
        hcnt_q <= hcnt_d;
        if (fall) high_q <= hcnt_q;
      end
    end

    assign high_w[g] = high_q;
`else
    assign high_ok = 1'b1;
`endif

    assign good = (cnt_q != CNT_MAX)
                && ({1'b0, cnt_q} >= LO)
                && ({1'b0, cnt_q} <= HI)
                && high_ok;

    always_comb begin
      cnt_d = cnt_q;
      if (rise) cnt_d = 28'd1;
      else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 28'd1;
    end

    always_ff @(posedge in_clock or posedge in_reset) begin
      if (in_reset) begin
        s1_q     <= 1'b0;
        s2_q     <= 1'b0;
        sd_q     <= 1'b0;
        seen_q   <= 1'b0;
        cnt_q    <= '0;
        period_q <= '0;
      end else begin
        s1_q  <= clk_a[g];
        s2_q  <= s1_q;
        sd_q  <= s2_q;
        cnt_q <= cnt_d;
        if (rise) begin
          seen_q <= 1'b1;
          if (seen_q) period_q <= cnt_q;
        end
      end
    end

    // Fault set in LOST is written last so it beats a same-cycle clear.
    always_ff @(posedge in_clock or posedge in_reset) begin
      if (in_reset) begin
        state_q <= SEARCH;
        good_q  <= '0;
        lock_q  <= 1'b0;
        fault_q <= 1'b0;
      end else begin
        if (bus.in_clear_fault) fault_q <= 1'b0;
        unique case (state_q)
          SEARCH: begin
            if (rise) begin
              state_q <= VERIFY;
              good_q  <= '0;
            end
          end
          VERIFY: begin
            if (rise) begin
              if (good) begin
                good_q <= good_q + 4'd1;
                if (good_q + 4'd1 == LOCK_N) begin
                  state_q <= LOCKED;
                  lock_q  <= 1'b1;
                end
              end else begin
                good_q <= '0;
              end
            end else if (cnt_q > TIMEOUT) begin
              state_q <= SEARCH;
            end
          end
          LOCKED: begin
            if (rise ? !good : (cnt_q > TIMEOUT))
              state_q <= LOST;
          end
          LOST: begin
            lock_q  <= 1'b0;
            fault_q <= 1'b1;
            state_q <= SEARCH;
          end
          default: state_q <= SEARCH;
        endcase
      end
    end

    assign lock_w[g]   = lock_q;
    assign fault_w[g]  = fault_q;
    assign period_w[g] = period_q;
  end

  assign bus.out_lock_GLONASS   = lock_w[0];
  assign bus.out_lock_GPS       = lock_w[1];
  assign bus.out_fault_GLONASS  = fault_w[0];
  assign bus.out_fault_GPS      = fault_w[1];
  assign bus.out_period_GLONASS = period_w[0];
  assign bus.out_period_GPS     = period_w[1];
`ifdef DUTY_CHECK_EN
  assign bus.out_high_GLONASS   = high_w[0];
  assign bus.out_high_GPS       = high_w[1];
`endif

endmodule

// File: tb/tb_gnss_clock_monitor.sv
// Directed bench for gnss_clock_monitor: lock, loss, timeout,
// tolerance, clear/set collision and async reset.
module tb_gnss_clock_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;

  always #5 clk = ~clk;

  gnss_clock_monitor_if bus();

  gnss_clock_monitor dut (
    .in_clock (clk),
    .in_reset (rst),
    .bus      (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  int   per_a [2]     = '{25, 50};
  int   per_b [2]     = '{25, 50};
  int   hi [2]        = '{12, 25};
  int   once_val [2]  = '{0, 0};
  int   once_tag [2]  = '{0, 0};
  int   once_seen [2] = '{0, 0};
  int   ph [2]        = '{0, 0};
  int   cur [2]       = '{25, 50};
  int   edges [2]     = '{0, 0};
  bit   en [2]        = '{1'b0, 1'b0};
  bit   alt [2]       = '{1'b0, 1'b0};
  logic ck [2]        = '{1'b0, 1'b0};

  assign bus.in_clock_GLONASS = ck[0];
  assign bus.in_clock_GPS     = ck[1];
  assign bus.in_clear_fault   = clr;

  // Divided-clock generator, stepped on the falling edge of clk.
  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (!en[c]) begin
        ck[c] = 1'b0;
        ph[c] = 0;
      end else begin
        if (ph[c] == 0) begin
          if (once_tag[c] != once_seen[c]) begin
            cur[c]       = once_val[c];
            once_seen[c] = once_tag[c];
          end else begin
            cur[c] = alt[c] ? per_b[c] : per_a[c];
            alt[c] = ~alt[c];
          end
          edges[c]++;
        end
        ck[c] = (ph[c] < hi[c]);
        ph[c] = (ph[c] + 1 >= cur[c]) ? 0 : ph[c] + 1;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_to(input int c, input int tgt);
    int k = 0;
    while (edges[c] < tgt && k < 3000) begin
      step();
      k++;
    end
    n_chk++;
    if (edges[c] < tgt) begin
      n_fail++;
      $display("FAIL wait_ch%0d: edges %0d, needed %0d",
               c, edges[c], tgt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    steps(3);
    n_chk++;
    if (bus.out_lock_GLONASS !== 1'b0 || bus.out_lock_GPS !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_lock: got %b%b expected 00",
               bus.out_lock_GLONASS, bus.out_lock_GPS);
    end
    n_chk++;
    if (bus.out_fault_GLONASS !== 1'b0 || bus.out_fault_GPS !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_fault: got %b%b expected 00",
               bus.out_fault_GLONASS, bus.out_fault_GPS);
    end
    n_chk++;
    if (bus.out_period_GLONASS !== 28'd0 || bus.out_period_GPS !== 28'd0) begin
      n_fail++;
      $display("FAIL reset_period: got %0d/%0d expected 0/0",
               bus.out_period_GLONASS, bus.out_period_GPS);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_lock();
    int b0, b1;
    b0 = edges[0];
    b1 = edges[1];
    en[0] = 1'b1;
    en[1] = 1'b1;
    wait_to(0, b0 + 5);
    steps(2);
    n_chk++;
    if (bus.out_lock_GLONASS !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_glo_early: got %b expected 0", bus.out_lock_GLONASS);
    end
    steps(2);
    n_chk++;
    if (bus.out_lock_GLONASS !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_glo: got %b expected 1", bus.out_lock_GLONASS);
    end
    wait_to(1, b1 + 5);
    steps(2);
    n_chk++;
    if (bus.out_lock_GPS !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_gps_early: got %b expected 0", bus.out_lock_GPS);
    end
    steps(2);
    n_chk++;
    if (bus.out_lock_GPS !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_gps: got %b expected 1", bus.out_lock_GPS);
    end
    n_chk++;
    if (bus.out_period_GLONASS !== 28'd25) begin
      n_fail++;
      $display("FAIL period_glo: got %0d expected 25", bus.out_period_GLONASS);
    end
    n_chk++;
    if (bus.out_period_GPS !== 28'd50) begin
      n_fail++;
      $display("FAIL period_gps: got %0d expected 50", bus.out_period_GPS);
    end
    n_chk++;
    if (bus.out_fault_GLONASS !== 1'b0 || bus.out_fault_GPS !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_faults: got %b%b expected 00",
               bus.out_fault_GLONASS, bus.out_fault_GPS);
    end
  endtask

  task automatic test_stretch();
    int e;
    e = edges[0];
    once_val[0] = 27;
    once_tag[0]++;
    wait_to(0, e + 2);
    steps(4);
    n_chk++;
    if (bus.out_lock_GLONASS !== 1'b0 || bus.out_fault_GLONASS !== 1'b1) begin
      n_fail++;
      $display("FAIL stretch_loss: lock %b fault %b expected lock 0 fault 1",
               bus.out_lock_GLONASS, bus.out_fault_GLONASS);
    end
    n_chk++;
    if (bus.out_period_GLONASS !== 28'd27) begin
      n_fail++;
      $display("FAIL stretch_period: got %0d expected 27", bus.out_period_GLONASS);
    end
    n_chk++;
    if (bus.out_lock_GPS !== 1'b1) begin
      n_fail++;
      $display("FAIL stretch_gps_lock: got %b expected 1", bus.out_lock_GPS);
    end
    wait_to(0, e + 7);
    steps(2);
    n_chk++;
    if (bus.out_lock_GLONASS !== 1'b0) begin
      n_fail++;
      $display("FAIL relock_early: got %b expected 0", bus.out_lock_GLONASS);
    end
    steps(2);
    n_chk++;
    if (bus.out_lock_GLONASS !== 1'b1 || bus.out_fault_GLONASS !== 1'b1) begin
      n_fail++;
      $display("FAIL relock: lock %b fault %b expected lock 1 fault 1",
               bus.out_lock_GLONASS, bus.out_fault_GLONASS);
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();
    n_chk++;
    if (bus.out_fault_GLONASS !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_fault: got %b expected 0", bus.out_fault_GLONASS);
    end
  endtask

  task automatic test_alternate();
    int e;
    e = edges[0];
    per_a[0] = 24;
    per_b[0] = 26;
    for (int k = 1; k <= 6; k++) begin
      wait_to(0, e + k);
      steps(4);
      n_chk++;
      if (bus.out_lock_GLONASS !== 1'b1 || bus.out_fault_GLONASS !== 1'b0) begin
        n_fail++;
        $display("FAIL alt_hold_%0d: lock %b fault %b expected lock 1 fault 0",
                 k, bus.out_lock_GLONASS, bus.out_fault_GLONASS);
      end
    end
    n_chk++;
    if (bus.out_period_GLONASS !== 28'd24 && bus.out_period_GLONASS !== 28'd26) begin
      n_fail++;
      $display("FAIL alt_period: got %0d expected 24 or 26",
               bus.out_period_GLONASS);
    end
    per_a[0] = 25;
    per_b[0] = 25;
    wait_to(0, e + 8);
  endtask

  task automatic test_gps_stall();
    int b;
    en[1] = 1'b0;
    steps(150);
    n_chk++;
    if (bus.out_lock_GPS !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_early: got %b expected 1", bus.out_lock_GPS);
    end
    steps(150);
    n_chk++;
    if (bus.out_lock_GPS !== 1'b0 || bus.out_fault_GPS !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_loss: lock %b fault %b expected lock 0 fault 1",
               bus.out_lock_GPS, bus.out_fault_GPS);
    end
    n_chk++;
    if (bus.out_lock_GLONASS !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_glo_lock: got %b expected 1", bus.out_lock_GLONASS);
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    b = edges[1];
    en[1] = 1'b1;
    wait_to(1, b + 2);
    en[1] = 1'b0;
    steps(300);
    n_chk++;
    if (bus.out_fault_GPS !== 1'b0 || bus.out_lock_GPS !== 1'b0) begin
      n_fail++;
      $display("FAIL verify_stall: lock %b fault %b expected lock 0 fault 0",
               bus.out_lock_GPS, bus.out_fault_GPS);
    end
    b = edges[1];
    en[1] = 1'b1;
    wait_to(1, b + 5);
    steps(4);
    n_chk++;
    if (bus.out_lock_GPS !== 1'b1) begin
      n_fail++;
      $display("FAIL gps_relock: got %b expected 1", bus.out_lock_GPS);
    end
  endtask

  task automatic test_clear_collision();
    int e;
    e = edges[0];
    once_val[0] = 27;
    once_tag[0]++;
    wait_to(0, e + 2);
    steps(2);
    clr = 1'b1;
    steps(2);
    clr = 1'b0;
    n_chk++;
    if (bus.out_lock_GLONASS !== 1'b0) begin
      n_fail++;
      $display("FAIL collide_lock: got %b expected 0", bus.out_lock_GLONASS);
    end
    step();
    n_chk++;
    if (bus.out_fault_GLONASS !== 1'b1) begin
      n_fail++;
      $display("FAIL collide_fault: got %b expected 1", bus.out_fault_GLONASS);
    end
  endtask

  task automatic test_async_reset();
    wait_to(0, edges[0] + 8);
    step();
    #3;
    rst = 1'b1;
    #1;
    n_chk++;
    if (bus.out_lock_GLONASS !== 1'b0 || bus.out_lock_GPS !== 1'b0 ||
        bus.out_fault_GLONASS !== 1'b0 || bus.out_fault_GPS !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst_flags: lock %b%b fault %b%b expected 0000",
               bus.out_lock_GLONASS, bus.out_lock_GPS,
               bus.out_fault_GLONASS, bus.out_fault_GPS);
    end
    n_chk++;
    if (bus.out_period_GLONASS !== 28'd0 || bus.out_period_GPS !== 28'd0) begin
      n_fail++;
      $display("FAIL async_rst_period: got %0d/%0d expected 0/0",
               bus.out_period_GLONASS, bus.out_period_GPS);
    end
    steps(3);
    rst = 1'b0;
    steps(2);
    n_chk++;
    if (bus.out_lock_GLONASS !== 1'b0 || bus.out_lock_GPS !== 1'b0 ||
        bus.out_period_GLONASS !== 28'd0) begin
      n_fail++;
      $display("FAIL rst_release: lock %b%b period %0d expected 00 and 0",
               bus.out_lock_GLONASS, bus.out_lock_GPS, bus.out_period_GLONASS);
    end
  endtask

  task automatic test_verify_bad();
    int b;
    per_a[0] = 23;
    per_b[0] = 25;
    b = edges[0];
    for (int k = 6; k <= 12; k++) begin
      wait_to(0, b + k);
      steps(4);
      n_chk++;
      if (bus.out_lock_GLONASS !== 1'b0) begin
        n_fail++;
        $display("FAIL verify_bad_%0d: got %b expected 0",
                 k, bus.out_lock_GLONASS);
      end
    end
    n_chk++;
    if (bus.out_period_GLONASS !== 28'd23 && bus.out_period_GLONASS !== 28'd25) begin
      n_fail++;
      $display("FAIL verify_bad_period: got %0d expected 23 or 25",
               bus.out_period_GLONASS);
    end
    per_a[0] = 25;
    per_b[0] = 25;
    wait_to(0, b + 20);
    steps(4);
    n_chk++;
    if (bus.out_lock_GLONASS !== 1'b1) begin
      n_fail++;
      $display("FAIL verify_recover: got %b expected 1", bus.out_lock_GLONASS);
    end
  endtask

`ifdef DUTY_CHECK_EN
  task automatic test_duty();
    int b;
    rst = 1'b1;
    steps(2);
    hi[0] = 18;
    rst = 1'b0;
    b = edges[0];
    wait_to(0, b + 10);
    steps(4);
    n_chk++;
    if (bus.out_lock_GLONASS !== 1'b0) begin
      n_fail++;
      $display("FAIL duty_bad_lock: got %b expected 0", bus.out_lock_GLONASS);
    end
    n_chk++;
    if (bus.out_high_GLONASS !== 28'd18) begin
      n_fail++;
      $display("FAIL duty_high18: got %0d expected 18", bus.out_high_GLONASS);
    end
    hi[0] = 12;
    wait_to(0, b + 18);
    steps(4);
    n_chk++;
    if (bus.out_lock_GLONASS !== 1'b1 || bus.out_high_GLONASS !== 28'd12) begin
      n_fail++;
      $display("FAIL duty_good: lock %b high %0d expected lock 1 high 12",
               bus.out_lock_GLONASS, bus.out_high_GLONASS);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_lock();
    test_stretch();
    test_alternate();
    test_gps_stall();
    test_clear_collision();
    test_async_reset();
    test_verify_bad();
`ifdef DUTY_CHECK_EN
    test_duty();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
